// File: rtl/pc_unit.sv
// pc_unit: fetch-stage program counter with stall/write-enable freeze, buffered redirects and a fetch counter.
// Optional PC_MISALIGN_TRAP_EN: misaligned applied redirects trap to TRAP_VECTOR instead of being aligned down.
module pc_unit #(
    parameter int              XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = '0,
    parameter logic [XLEN-1:0] TRAP_VECTOR  = XLEN'('h100),
    parameter int              INSN_BYTES   = 4,
    parameter int              CNT_W        = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic             stall_i,
    input  logic             pc_write_i,
    input  logic             redirect_valid_i,
    input  logic [XLEN-1:0]  redirect_pc_i,
    output logic [XLEN-1:0]  pc_o,
    output logic             pc_valid_o,
    output logic             redirect_pend_o,
    output logic             misalign_o,
    output logic [CNT_W-1:0] fetch_cnt_o
);
    typedef enum logic {IDLE, RUN} state_t;
    localparam logic [XLEN-1:0] ALIGN_MASK = XLEN'(INSN_BYTES - 1);
    state_t r_state, w_state_next;
    logic [XLEN-1:0] r_pc, r_pend_pc, w_target, w_applied, w_pc_next;
    logic [CNT_W-1:0] r_cnt;
    logic r_pend, r_misalign, w_run, w_adv, w_use_redir, w_misalign;

    always_ff @(posedge clk_i or posedge rst_i)
        if (rst_i) r_state <= IDLE;
        else r_state <= w_state_next;

    always_comb w_state_next = start_i ? RUN : IDLE;

    always_comb pc_valid_o = (r_state == RUN);

    always_comb begin
        w_run       = (r_state == RUN) && start_i;
        w_adv       = w_run && !stall_i && pc_write_i;
        w_use_redir = redirect_valid_i || r_pend;
        w_target    = redirect_valid_i ? redirect_pc_i : r_pend_pc;
`ifdef PC_MISALIGN_TRAP_EN
        w_misalign  = w_adv && w_use_redir && ((w_target & ALIGN_MASK) != '0);
        w_applied   = ((w_target & ALIGN_MASK) != '0) ? TRAP_VECTOR : w_target;
`else
        w_misalign  = 1'b0;
        w_applied   = w_target & ~ALIGN_MASK;
`endif
        w_pc_next   = w_use_redir ? w_applied : r_pc + XLEN'(INSN_BYTES);
    end

    // Leaving RUN (or sitting in IDLE) parks the PC at the reset vector and drops any buffered redirect.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_pc       <= RESET_VECTOR;
            r_pend     <= 1'b0;
            r_pend_pc  <= '0;
            r_cnt      <= '0;
            r_misalign <= 1'b0;
        end else begin
            r_misalign <= w_misalign;
            if (!w_run) begin
                r_pc   <= RESET_VECTOR;
                r_pend <= 1'b0;
            end else if (w_adv) begin
                r_pc   <= w_pc_next;
                r_pend <= 1'b0;
                r_cnt  <= r_cnt + CNT_W'(1);
            end else if (redirect_valid_i) begin
                r_pend    <= 1'b1;
                r_pend_pc <= redirect_pc_i;
            end
        end
    end

    assign pc_o            = r_pc;
    assign redirect_pend_o = r_pend;
    assign misalign_o      = r_misalign;
    assign fetch_cnt_o     = r_cnt;
endmodule

// File: tb/tb_pc_unit.sv
// tb_pc_unit: table vectors, hand sequences for reset/wrap/misalign corners, and randomized run against a reference model.
module tb_pc_unit;
    logic clk_i = 0, rst_i = 1, start_i = 0, stall_i = 0, pc_write_i = 1, redirect_valid_i = 0;
    logic [31:0] redirect_pc_i = 0;
    logic [31:0] pc_o, fetch_cnt_o, cnt8;
    logic [7:0] pc8;
    logic pc_valid_o, redirect_pend_o, misalign_o, valid8, pend8, mis8;
    int n_cmp = 0, n_bad = 0;
`ifdef PC_MISALIGN_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    pc_unit dut (.clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .stall_i(stall_i), .pc_write_i(pc_write_i),
                 .redirect_valid_i(redirect_valid_i), .redirect_pc_i(redirect_pc_i), .pc_o(pc_o),
                 .pc_valid_o(pc_valid_o), .redirect_pend_o(redirect_pend_o), .misalign_o(misalign_o),
                 .fetch_cnt_o(fetch_cnt_o));
    pc_unit #(.XLEN(8)) dut8 (.clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .stall_i(stall_i),
                 .pc_write_i(pc_write_i), .redirect_valid_i(redirect_valid_i), .redirect_pc_i(redirect_pc_i[7:0]),
                 .pc_o(pc8), .pc_valid_o(valid8), .redirect_pend_o(pend8), .misalign_o(mis8), .fetch_cnt_o(cnt8));

    always #5 clk_i = ~clk_i;

    bit m_run, m_pend, m_mis;
    logic [31:0] m_pc, m_pend_pc, m_cnt;

    task automatic model_reset();
        m_run = 0; m_pc = 0; m_pend = 0; m_pend_pc = 0; m_cnt = 0; m_mis = 0;
    endtask

    task automatic model_step();
        logic [31:0] t;
        m_mis = 0;
        if (!start_i) begin
            m_run = 0; m_pc = 0; m_pend = 0;
        end else if (!m_run) begin
            m_run = 1;
        end else if (!stall_i && pc_write_i) begin
            if (redirect_valid_i || m_pend) begin
                t = redirect_valid_i ? redirect_pc_i : m_pend_pc;
                if (t % 4 == 0) m_pc = t;
                else if (TRAP) begin m_pc = 32'h100; m_mis = 1; end
                else m_pc = t - t % 4;
            end else m_pc = m_pc + 4;
            m_pend = 0;
            m_cnt = m_cnt + 1;
        end else if (redirect_valid_i) begin
            m_pend = 1; m_pend_pc = redirect_pc_i;
        end
    endtask

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic cmp_model(string nm);
        chk({nm, ".pc"}, pc_o, m_pc);
        chk({nm, ".valid"}, pc_valid_o, m_run);
        chk({nm, ".pend"}, redirect_pend_o, m_pend);
        chk({nm, ".mis"}, misalign_o, m_mis);
        chk({nm, ".cnt"}, fetch_cnt_o, m_cnt);
    endtask

    task automatic tick();
        @(posedge clk_i);
        model_step();
        #1;
    endtask

    typedef struct {
        bit st, sl, pw, rv;
        logic [31:0] rpc, pc;
        bit vld, pend;
        logic [31:0] cnt;
    } vec_t;
    vec_t q[$];

    task automatic add(bit st, bit sl, bit pw, bit rv, logic [31:0] rpc, logic [31:0] pc, bit vld, bit pend,
                       logic [31:0] cnt);
        vec_t v;
        v.st = st; v.sl = sl; v.pw = pw; v.rv = rv; v.rpc = rpc; v.pc = pc; v.vld = vld; v.pend = pend; v.cnt = cnt;
        q.push_back(v);
    endtask

    initial begin
        model_reset();
        repeat (2) @(posedge clk_i);
        #1 rst_i = 0;
        chk("rst.pc", pc_o, 0);
        chk("rst.valid", pc_valid_o, 0);
        chk("rst.cnt", fetch_cnt_o, 0);
        chk("rst.pend", redirect_pend_o, 0);
        chk("rst.mis", misalign_o, 0);
        add(1,0,1,0,0,      32'h00,1,0,0);
        add(1,0,1,0,0,      32'h04,1,0,1);
        add(1,0,1,0,0,      32'h08,1,0,2);
        add(1,0,1,0,0,      32'h0C,1,0,3);
        add(1,0,1,0,0,      32'h10,1,0,4);
        add(1,1,1,1,32'h80, 32'h10,1,1,4);
        add(1,1,1,1,32'h90, 32'h10,1,1,4);
        add(1,1,1,0,0,      32'h10,1,1,4);
        add(1,0,1,0,0,      32'h90,1,0,5);
        add(1,0,1,0,0,      32'h94,1,0,6);
        add(1,0,0,1,32'h80, 32'h94,1,1,6);
        add(1,0,1,1,32'hA0, 32'hA0,1,0,7);
        add(1,0,1,0,0,      32'hA4,1,0,8);
        add(0,0,1,1,32'hC0, 32'h00,0,0,8);
        add(0,0,1,1,32'hC4, 32'h00,0,0,8);
        foreach (q[i]) begin
            start_i = q[i].st; stall_i = q[i].sl; pc_write_i = q[i].pw;
            redirect_valid_i = q[i].rv; redirect_pc_i = q[i].rpc;
            tick();
            chk($sformatf("vec%0d.pc", i), pc_o, q[i].pc);
            chk($sformatf("vec%0d.valid", i), pc_valid_o, q[i].vld);
            chk($sformatf("vec%0d.pend", i), redirect_pend_o, q[i].pend);
            chk($sformatf("vec%0d.cnt", i), fetch_cnt_o, q[i].cnt);
            chk($sformatf("vec%0d.mis", i), misalign_o, 0);
        end
        start_i = 1; redirect_valid_i = 0; stall_i = 0; pc_write_i = 1;
        tick();
        redirect_valid_i = 1; redirect_pc_i = 32'h40;
        tick();
        chk("t1.pc_before", pc_o, 32'h40);
        redirect_valid_i = 0;
        #2 rst_i = 1;
        #1;
        chk("t1.pc_async", pc_o, 0);
        chk("t1.valid_async", pc_valid_o, 0);
        chk("t1.cnt_async", fetch_cnt_o, 0);
        model_reset();
        start_i = 0;
        @(posedge clk_i);
        #1 rst_i = 0;
        start_i = 1;
        tick();
        redirect_valid_i = 1; redirect_pc_i = 32'hFC;
        tick();
        chk("t5.pc_fc", pc8, 8'hFC);
        chk("t5.cnt1", cnt8, 1);
        redirect_valid_i = 0;
        tick();
        chk("t5.pc_wrap", pc8, 8'h00);
        chk("t5.cnt2", cnt8, 2);
        chk("t5.valid", valid8, 1);
        start_i = 0;
        tick();
        chk("t5.pc_idle", pc8, 8'h00);
        chk("t5.cnt_held", cnt8, 2);
        chk("t5.valid_idle", valid8, 0);
        chk("t5.pend", pend8, 0);
        chk("t5.mis", mis8, 0);
        cmp_model("t5");
        start_i = 1;
        tick();
        redirect_valid_i = 1; redirect_pc_i = 32'h82;
        tick();
        chk("t6.pc", pc_o, TRAP ? 32'h100 : 32'h80);
        chk("t6.mis", misalign_o, TRAP);
        redirect_valid_i = 0;
        tick();
        chk("t6.mis_clr", misalign_o, 0);
        chk("t6.pc_next", pc_o, TRAP ? 32'h104 : 32'h84);
        stall_i = 1; redirect_valid_i = 1; redirect_pc_i = 32'h86;
        tick();
        chk("t6.pend", redirect_pend_o, 1);
        chk("t6.mis_held", misalign_o, 0);
        stall_i = 0; redirect_valid_i = 0;
        tick();
        chk("t6.pend_pc", pc_o, TRAP ? 32'h100 : 32'h84);
        chk("t6.pend_mis", misalign_o, TRAP);
        chk("t6.pend_clr", redirect_pend_o, 0);
        cmp_model("t6");
        for (int i = 0; i < 3000; i++) begin
            start_i = ($urandom_range(99) < 93);
            stall_i = ($urandom_range(99) < 20);
            pc_write_i = ($urandom_range(99) < 80);
            redirect_valid_i = ($urandom_range(99) < 25);
            redirect_pc_i = $urandom;
            if ($urandom_range(1)) redirect_pc_i[1:0] = 2'b00;
            tick();
            cmp_model($sformatf("rnd%0d", i));
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
